imm_ext_pipe: RTL and testbench



---
 rtl/imm_ext_pipe.sv | 115 +++++++++++
 tb/tb_imm_ext_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage with a two-entry skid buffer between decode and execute.
// Optional macro IMM_BRANCH_SHIFT_EN turns mode 11 into a sign-extended, <<2 branch offset.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);
    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zext_w;
    logic [OUT_W-1:0] sext_w;
    logic [OUT_W-1:0] ext_w;

    always_comb begin
        zext_w = {{PAD_W{1'b0}}, in_imm};
        sext_w = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
        case (in_mode)
            2'b00:   ext_w = zext_w;
            2'b01:   ext_w = sext_w;
            2'b10:   ext_w = {in_imm, {PAD_W{1'b0}}};
`ifdef IMM_BRANCH_SHIFT_EN
            default: ext_w = {sext_w[OUT_W-3:0], 2'b00};
`else
            default: ext_w = sext_w;
`endif
        endcase
    end

    logic             main_valid_reg, main_valid_next;
    logic [OUT_W-1:0] main_imm_reg,   main_imm_next;
    logic [TAG_W-1:0] main_tag_reg,   main_tag_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [OUT_W-1:0] skid_imm_reg,   skid_imm_next;
    logic [TAG_W-1:0] skid_tag_reg,   skid_tag_next;
    logic             in_ready_reg;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = main_valid_reg & out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_imm_next   = main_imm_reg;
        main_tag_next   = main_tag_reg;
        skid_valid_next = skid_valid_reg;
        skid_imm_next   = skid_imm_reg;
        skid_tag_next   = skid_tag_reg;
        if (flush) begin
            // Data registers keep their contents; only the valid bits are dropped.
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (out_fire || !main_valid_reg) begin
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_imm_next   = skid_imm_reg;
                main_tag_next   = skid_tag_reg;
                skid_valid_next = in_fire;
                if (in_fire) begin
                    skid_imm_next = ext_w;
                    skid_tag_next = in_tag;
                end
            end else begin
                main_valid_next = in_fire;
                if (in_fire) begin
                    main_imm_next = ext_w;
                    main_tag_next = in_tag;
                end
            end
        end else if (in_fire) begin
            skid_valid_next = 1'b1;
            skid_imm_next   = ext_w;
            skid_tag_next   = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            main_imm_reg   <= '0;
            main_tag_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_imm_reg   <= '0;
            skid_tag_reg   <= '0;
            in_ready_reg   <= 1'b0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_imm_reg   <= main_imm_next;
            main_tag_reg   <= main_tag_next;
            skid_valid_reg <= skid_valid_next;
            skid_imm_reg   <= skid_imm_next;
            skid_tag_reg   <= skid_tag_next;
            // Ready looks one entry ahead so no path runs from out_ready to in_ready.
            in_ready_reg   <= !skid_valid_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign out_imm   = main_imm_reg;
    assign out_tag   = main_tag_reg;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed literal checks plus a randomized run
// compared each cycle against a queue-based model of the two-entry stage.
module tb_imm_ext_pipe;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm = '0;
    logic [1:0]       in_mode = 2'b00;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;

    imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Extension from the arithmetic meaning of each mode.
    function automatic logic [OUT_W-1:0] ext_model(input logic [1:0] m, input logic [IN_W-1:0] v);
        longint unsigned u;
        longint unsigned s;
        u = 64'(v);
        s = v[IN_W-1] ? u - (64'd1 << IN_W) : u;
        case (m)
            2'b00:   return OUT_W'(u);
            2'b01:   return OUT_W'(s);
            2'b10:   return OUT_W'(u * (64'd1 << (OUT_W - IN_W)));
`ifdef IMM_BRANCH_SHIFT_EN
            default: return OUT_W'(s * 4);
`else
            default: return OUT_W'(s);
`endif
        endcase
    endfunction

    typedef struct {
        logic [OUT_W-1:0] imm;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t q[$];
    bit   model_rdy = 1'b0;
    bit   zero_hold = 1'b0;
    bit   cmp_en = 1'b0;

    // Model: a FIFO of at most two entries; ready means room for one more after this edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            model_rdy = 1'b0;
            zero_hold = 1'b1;
            cmp_en    = 1'b1;
        end else if (flush) begin
            q.delete();
            model_rdy = 1'b1;
        end else begin
            bit acc;
            ent_t e;
            acc = in_valid && model_rdy;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                e.imm = ext_model(in_mode, in_imm);
                e.tag = in_tag;
                q.push_back(e);
            end
            if (q.size() > 0) zero_hold = 1'b0;
            model_rdy = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("cyc_in_ready", 64'(in_ready), 64'(model_rdy));
            if (q.size() > 0) begin
                chk("cyc_out_imm", 64'(out_imm), 64'(q[0].imm));
                chk("cyc_out_tag", 64'(out_tag), 64'(q[0].tag));
            end else if (zero_hold) begin
                chk("cyc_reset_imm", 64'(out_imm), 64'd0);
                chk("cyc_reset_tag", 64'(out_tag), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] m, input logic [IN_W-1:0] imm,
                         input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_mode  = m;
        in_imm   = imm;
        in_tag   = tag;
    endtask

    initial begin
        logic [OUT_W-1:0] br_exp;
`ifdef IMM_BRANCH_SHIFT_EN
        br_exp = 32'hFFFF_FFFC;
`else
        br_exp = 32'hFFFF_FFFF;
`endif
        // Reset
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Modes back-to-back
        out_ready = 1'b1;
        drive(1, 2'b01, 16'h8001, 5'd5);  step();
        chk("sext_valid", 64'(out_valid), 64'd1);
        chk("sext_imm", 64'(out_imm), 64'hFFFF8001);
        chk("sext_tag", 64'(out_tag), 64'd5);
        drive(1, 2'b00, 16'h8001, 5'd6);  step();
        chk("zext_imm", 64'(out_imm), 64'h00008001);
        chk("zext_tag", 64'(out_tag), 64'd6);
        drive(1, 2'b10, 16'h1234, 5'd7);  step();
        chk("lui_imm", 64'(out_imm), 64'h12340000);
        chk("lui_tag", 64'(out_tag), 64'd7);
        drive(1, 2'b11, 16'hFFFF, 5'd8);  step();
        chk("br_imm", 64'(out_imm), 64'(br_exp));
        chk("br_tag", 64'(out_tag), 64'd8);
        drive(0, 2'b00, 16'h0, 5'd0);     step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        $display("directed: modes done");

        // Back-pressure
        out_ready = 1'b0;
        drive(1, 2'b00, 16'h0001, 5'd1);  step();
        drive(1, 2'b00, 16'h0002, 5'd2);  step();
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        drive(1, 2'b00, 16'h0003, 5'd3);  step(); step();
        chk("bp_hold_tag", 64'(out_tag), 64'd1);
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;                 step();
        chk("bp_out2_tag", 64'(out_tag), 64'd2);
        step();
        chk("bp_out3_tag", 64'(out_tag), 64'd3);
        chk("bp_out3_imm", 64'(out_imm), 64'd3);
        drive(0, 2'b00, 16'h0, 5'd0);     step();
        chk("bp_empty", 64'(out_valid), 64'd0);
        $display("directed: back-pressure done");

        // Simultaneous push/pop, 8 cycles
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'b01, 16'(i * 16'h1111), 5'(10 + i));
            step();
            chk("sim_tag", 64'(out_tag), 64'(10 + i));
            chk("sim_in_ready", 64'(in_ready), 64'd1);
        end
        drive(0, 2'b00, 16'h0, 5'd0);     step();
        $display("directed: streaming done");

        // Flush with both entries full and input pending
        out_ready = 1'b0;
        drive(1, 2'b00, 16'h0014, 5'd20); step();
        drive(1, 2'b00, 16'h0015, 5'd21); step();
        drive(1, 2'b00, 16'h0016, 5'd22); flush = 1'b1; step();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        drive(1, 2'b00, 16'h0055, 5'd23); step();
        drive(0, 2'b00, 16'h0, 5'd0);
        chk("post_flush_valid", 64'(out_valid), 64'd1);
        chk("post_flush_tag", 64'(out_tag), 64'd23);
        chk("post_flush_imm", 64'(out_imm), 64'h55);
        $display("directed: flush done");

        // Reset mid-stream
        drive(1, 2'b01, 16'hABCD, 5'd9);  step();
        rst_n = 1'b0;                     step();
        rst_n = 1'b1;
        drive(0, 2'b00, 16'h0, 5'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_imm", 64'(out_imm), 64'd0);
        chk("mid_rst_tag", 64'(out_tag), 64'd0);
        out_ready = 1'b1;
        step(); step();
        chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
        $display("directed: mid-stream reset done");

        // Randomized traffic checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom), 5'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            rst_n     = ($urandom_range(0, 249) != 0);
            step();
        end
        rst_n = 1'b1; flush = 1'b0; drive(0, 2'b00, 16'h0, 5'd0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
